audio_stream_writer: RTL and testbench

- Upstream feeder for the I2S transmit stage.
- Parses a framed audio stream arriving as bytes from the USB FIFO receive path: a header carrying the stream configuration and payload length, then the payload.
- Forwards payload bytes into the I2S output FIFO write port, honouring the full flag.
- Drives the sample rate and bit depth configuration seen by the I2S transmitter; never changes it while the transmitter is streaming.

---
 rtl/audio_stream_pkg.sv | 71 +++++++
 rtl/audio_stream_writer_hold.sv | 52 +++++
 rtl/audio_stream_writer.sv | 233 +++++++++++++++++++++++
 tb/tb_audio_stream_writer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_stream_pkg.sv
// Shared types, constants and helpers for the audio stream writer.
// Bit-depth codes mirror the BIT_DEPTH_* encodings of definitions.svh.
package audio_stream_pkg;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
  localparam int         LEN_W_DEFAULT = 32;

  localparam logic [1:0] BIT_DEPTH_16  = 2'd0;
  localparam logic [1:0] BIT_DEPTH_24  = 2'd1;
  localparam logic [1:0] BIT_DEPTH_32  = 2'd2;
  localparam logic [1:0] BIT_DEPTH_DOP = 2'd3;

  // CFG byte field positions
  localparam int CFG_RATE_LSB  = 0;
  localparam int CFG_RATE_MSB  = 2;
  localparam int CFG_DEPTH_LSB = 3;
  localparam int CFG_DEPTH_MSB = 4;
  localparam int CFG_RSVD_LSB  = 5;
  localparam int CFG_RSVD_MSB  = 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CFG     = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHECK   = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_ERROR   = 3'd6
  } state_e;

  // Bytes per stereo frame for a bit-depth code
  function automatic logic [3:0] frame_bytes(input logic [1:0] bit_depth);
    logic [3:0] fb;
    case (bit_depth)
      BIT_DEPTH_16:  fb = 4'd4;
      BIT_DEPTH_24:  fb = 4'd6;
      BIT_DEPTH_32:  fb = 4'd8;
      BIT_DEPTH_DOP: fb = 4'd6;
      default:       fb = 4'd4;
    endcase
    return fb;
  endfunction

  // Running (length mod 3) update for one more big-endian byte.
  // 256 == 1 (mod 3) and 4 == 1 (mod 3), so folding 2-bit digits is enough.
  function automatic logic [1:0] mod3_add(input logic [1:0] acc, input logic [7:0] b);
    logic [3:0] s1;
    logic [2:0] s2;
    logic [1:0] s3;
    s1 = {2'b00, b[1:0]} + {2'b00, b[3:2]} + {2'b00, b[5:4]} + {2'b00, b[7:6]} + {2'b00, acc};
    s2 = {1'b0, s1[1:0]} + {1'b0, s1[3:2]};
    s3 = s2[1:0] + {1'b0, s2[2]};
    return (s3 == 2'd3) ? 2'd0 : s3;
  endfunction

  // Length is a whole number of frames: low bits give the power-of-two
  // part, the mod-3 tracker gives the factor of three in 6-byte frames.
  function automatic logic frame_aligned(input logic [1:0] bit_depth,
                                         input logic [2:0] len_lo,
                                         input logic [1:0] mod3);
    logic ok;
    case (frame_bytes(bit_depth))
      4'd4:    ok = (len_lo[1:0] == 2'd0);
      4'd8:    ok = (len_lo == 3'd0);
      4'd6:    ok = (len_lo[0] == 1'b0) && (mod3 == 2'd0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/audio_stream_writer_hold.sv
// One-entry hold register between the byte input and the output FIFO.
// The write strobe is gated combinationally by full so the FIFO is never
// written while full; a new byte can enter in the same cycle the old one leaves.
module stream_hold_reg (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clear_i,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       full_i,
  output logic       ready_o,
  output logic       valid_o,
  output logic       wr_en_o,
  output logic [7:0] wr_data_o
);

  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;

  assign wr_en_o   = valid_q & ~full_i & ~clear_i;
  assign ready_o   = ~valid_q | ~full_i;
  assign valid_o   = valid_q;
  assign wr_data_o = data_q;

  // Next hold contents: clear wins, then load, then drain on write
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (wr_en_o) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Hold register state
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/audio_stream_writer.sv
// Framed audio stream parser feeding the I2S output FIFO.
// Frame: MAGIC, CFG, LEN (big-endian), payload.
// Optional trailing XOR checksum byte: define AUDIO_STREAM_CHECKSUM_EN.
module audio_stream_writer
  import audio_stream_pkg::*;
#(
  parameter logic [7:0] MAGIC = MAGIC_DEFAULT,
  parameter int         LEN_W = LEN_W_DEFAULT
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  input  logic       abort_i,
  input  logic       output_streaming_i,
  input  logic       wr_output_FIFO_full_i,
  output logic       wr_output_FIFO_en_o,
  output logic [7:0] wr_output_FIFO_data_o,
  output logic [2:0] sample_rate_o,
  output logic [1:0] bit_depth_o,
  output logic       stream_active_o,
  output logic       stream_done_o,
  output logic       error_o
);

  localparam int LEN_BYTES = LEN_W / 8;
  localparam int IDX_W     = (LEN_BYTES > 1) ? $clog2(LEN_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN_BYTES - 1);

  state_e             state_q, state_d;
  logic [4:0]         pend_cfg_q, pend_cfg_d;
  logic [LEN_W-9:0]   shift_q, shift_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         mod3_q, mod3_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         rate_q, rate_d;
  logic [1:0]         depth_q, depth_d;
  logic               error_q, error_d;
`ifdef AUDIO_STREAM_CHECKSUM_EN
  logic [7:0]         xor_q, xor_d;
`endif

  logic               rx_ready_s, accept_s, hold_load_s, done_s;
  logic               hold_ready_s, hold_valid_s, hold_wr_en_s;
  logic [7:0]         hold_data_s;
  logic [LEN_W-1:0]   len_full_s;
  logic [1:0]         mod3_next_s;

  assign len_full_s  = {shift_q, rx_data_i};
  assign mod3_next_s = mod3_add(mod3_q, rx_data_i);
  assign accept_s    = rx_valid_i & rx_ready_s;

  stream_hold_reg u_hold (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   (abort_i),
    .load_i    (hold_load_s),
    .data_i    (rx_data_i),
    .full_i    (wr_output_FIFO_full_i),
    .ready_o   (hold_ready_s),
    .valid_o   (hold_valid_s),
    .wr_en_o   (hold_wr_en_s),
    .wr_data_o (hold_data_s)
  );

  // Input handshake per state; nothing is taken in an abort cycle
  always_comb begin
    rx_ready_s = 1'b0;
    case (state_q)
      ST_IDLE:    rx_ready_s = 1'b1;
      ST_CFG:     rx_ready_s = ~output_streaming_i;
      ST_LEN:     rx_ready_s = 1'b1;
      ST_PAYLOAD: rx_ready_s = hold_ready_s;
`ifdef AUDIO_STREAM_CHECKSUM_EN
      ST_CHECK:   rx_ready_s = 1'b1;
`endif
      default:    rx_ready_s = 1'b0;
    endcase
    rx_ready_s = rx_ready_s & ~abort_i;
  end

  // Next-state, header parsing, payload counting and done pulse
  always_comb begin
    state_d     = state_q;
    pend_cfg_d  = pend_cfg_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    mod3_d      = mod3_q;
    cnt_d       = cnt_q;
    rate_d      = rate_q;
    depth_d     = depth_q;
    hold_load_s = 1'b0;
    done_s      = 1'b0;
`ifdef AUDIO_STREAM_CHECKSUM_EN
    xor_d       = xor_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s && (rx_data_i == MAGIC)) state_d = ST_CFG;
        else                                  state_d = ST_IDLE;
      end
      ST_CFG: begin
        if (!accept_s) begin
          state_d = ST_CFG;
        end else if (rx_data_i[CFG_RSVD_MSB:CFG_RSVD_LSB] != 3'd0) begin
          state_d = ST_ERROR;
        end else begin
          pend_cfg_d = rx_data_i[CFG_DEPTH_MSB:CFG_RATE_LSB];
          shift_d    = {(LEN_W-8){1'b0}};
          idx_d      = {IDX_W{1'b0}};
          mod3_d     = 2'd0;
          state_d    = ST_LEN;
        end
      end
      ST_LEN: begin
        if (!accept_s) begin
          state_d = ST_LEN;
        end else if (idx_q != LAST_IDX) begin
          shift_d = len_full_s[LEN_W-9:0];
          mod3_d  = mod3_next_s;
          idx_d   = idx_q + IDX_W'(1);
        end else if (len_full_s == {LEN_W{1'b0}}) begin
          state_d = ST_ERROR;
        end else if (!frame_aligned(pend_cfg_q[4:3], len_full_s[2:0], mod3_next_s)) begin
          state_d = ST_ERROR;
        end else begin
          cnt_d   = len_full_s;
          rate_d  = pend_cfg_q[2:0];
          depth_d = pend_cfg_q[4:3];
`ifdef AUDIO_STREAM_CHECKSUM_EN
          xor_d   = 8'h00;
`endif
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (accept_s) begin
          hold_load_s = 1'b1;
          cnt_d       = cnt_q - LEN_W'(1);
`ifdef AUDIO_STREAM_CHECKSUM_EN
          xor_d       = xor_q ^ rx_data_i;
          if (cnt_q == LEN_W'(1)) state_d = ST_CHECK;
          else                    state_d = ST_PAYLOAD;
`else
          if (cnt_q == LEN_W'(1)) state_d = ST_DRAIN;
          else                    state_d = ST_PAYLOAD;
`endif
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
`ifdef AUDIO_STREAM_CHECKSUM_EN
      ST_CHECK: begin
        if (!accept_s) begin
          state_d = ST_CHECK;
        end else if (rx_data_i != xor_q) begin
          state_d = ST_ERROR;
        end else if (hold_valid_s && !hold_wr_en_s) begin
          state_d = ST_DRAIN;
        end else begin
          // last byte leaves now, or already left while waiting for the trailer
          done_s  = 1'b1;
          state_d = ST_IDLE;
        end
      end
`endif
      ST_DRAIN: begin
        if (hold_wr_en_s) begin
          done_s  = 1'b1;
          state_d = ST_IDLE;
        end else if (!hold_valid_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
    if (abort_i) begin
      state_d     = ST_IDLE;
      cnt_d       = {LEN_W{1'b0}};
      hold_load_s = 1'b0;
      done_s      = 1'b0;
    end else begin
      state_d     = state_d;
    end
    error_d = (state_d == ST_ERROR);
  end

  // State and configuration registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      pend_cfg_q <= 5'd0;
      shift_q    <= {(LEN_W-8){1'b0}};
      idx_q      <= {IDX_W{1'b0}};
      mod3_q     <= 2'd0;
      cnt_q      <= {LEN_W{1'b0}};
      rate_q     <= 3'd0;
      depth_q    <= BIT_DEPTH_16;
      error_q    <= 1'b0;
`ifdef AUDIO_STREAM_CHECKSUM_EN
      xor_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      pend_cfg_q <= pend_cfg_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      mod3_q     <= mod3_d;
      cnt_q      <= cnt_d;
      rate_q     <= rate_d;
      depth_q    <= depth_d;
      error_q    <= error_d;
`ifdef AUDIO_STREAM_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  assign rx_ready_o            = rx_ready_s;
  assign wr_output_FIFO_en_o   = hold_wr_en_s;
  assign wr_output_FIFO_data_o = hold_data_s;
  assign sample_rate_o         = rate_q;
  assign bit_depth_o           = depth_q;
  assign stream_active_o       = (state_q == ST_PAYLOAD) || (state_q == ST_CHECK) ||
                                 (state_q == ST_DRAIN);
  assign stream_done_o         = done_s;
  assign error_o               = error_q;

endmodule

// File: tb/tb_audio_stream_writer.sv
// Directed bench for audio_stream_writer (works with or without
// AUDIO_STREAM_CHECKSUM_EN; trailer bytes are added when it is defined).
module tb_audio_stream_writer;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic [7:0] rx_data_i = 8'h00;
  logic       rx_valid_i = 1'b0;
  logic       rx_ready_o;
  logic       abort_i = 1'b0;
  logic       output_streaming_i = 1'b0;
  logic       wr_output_FIFO_full_i = 1'b0;
  logic       wr_output_FIFO_en_o;
  logic [7:0] wr_output_FIFO_data_o;
  logic [2:0] sample_rate_o;
  logic [1:0] bit_depth_o;
  logic       stream_active_o;
  logic       stream_done_o;
  logic       error_o;

  int n_cmp = 0;
  int n_err = 0;
  int timeouts = 0;
  int done_cnt = 0;
  int full_wr_cnt = 0;
  logic [7:0] wr_q[$];

  audio_stream_writer dut (
    .clk_i                 (clk_i),
    .reset_i               (reset_i),
    .rx_data_i             (rx_data_i),
    .rx_valid_i            (rx_valid_i),
    .rx_ready_o            (rx_ready_o),
    .abort_i               (abort_i),
    .output_streaming_i    (output_streaming_i),
    .wr_output_FIFO_full_i (wr_output_FIFO_full_i),
    .wr_output_FIFO_en_o   (wr_output_FIFO_en_o),
    .wr_output_FIFO_data_o (wr_output_FIFO_data_o),
    .sample_rate_o         (sample_rate_o),
    .bit_depth_o           (bit_depth_o),
    .stream_active_o       (stream_active_o),
    .stream_done_o         (stream_done_o),
    .error_o               (error_o)
  );

  always #5 clk_i = ~clk_i;

  // Record FIFO writes and done pulses between clock edges
  always @(negedge clk_i) begin
    if (wr_output_FIFO_en_o === 1'b1) begin
      wr_q.push_back(wr_output_FIFO_data_o);
      if (wr_output_FIFO_full_i) full_wr_cnt++;
    end
    if (stream_done_o === 1'b1) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(negedge clk_i);
    while (rx_ready_o !== 1'b1 && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    if (k >= 200) timeouts++;
    @(posedge clk_i);
    #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic send_header(input logic [7:0] cfg, input logic [31:0] len);
    send_byte(8'hA5);
    send_byte(cfg);
    send_byte(len[31:24]);
    send_byte(len[23:16]);
    send_byte(len[15:8]);
    send_byte(len[7:0]);
  endtask

  task automatic send_payload(input logic [7:0] first, input int n, input bit corrupt);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      send_byte(first + 8'(i));
      x = x ^ (first + 8'(i));
    end
`ifdef AUDIO_STREAM_CHECKSUM_EN
    send_byte(corrupt ? 8'hFF : x);
`endif
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic check_writes(input string tag, input logic [7:0] first, input int n);
    check({tag, "_count"}, wr_q.size(), n);
    for (int i = 0; i < n && i < wr_q.size(); i++)
      check({tag, "_data"}, wr_q[i], first + 8'(i));
  endtask

  initial begin
    // ---- reset ----
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    check("rst_ready", rx_ready_o, 1);
    check("rst_wr_en", wr_output_FIFO_en_o, 0);
    check("rst_rate", sample_rate_o, 0);
    check("rst_depth", bit_depth_o, 0);
    check("rst_active", stream_active_o, 0);
    check("rst_done", stream_done_o, 0);
    check("rst_error", error_o, 0);
    @(posedge clk_i); #1;

    // ---- 1: 24-bit stream, resync byte first ----
    wr_q.delete(); done_cnt = 0;
    send_byte(8'h00);
    send_header(8'h09, 32'h0000000C);
    @(negedge clk_i);
    check("t1_active", stream_active_o, 1);
    @(posedge clk_i); #1;
    send_payload(8'h10, 12, 1'b0);
    idle_cycles(4);
    check_writes("t1", 8'h10, 12);
    check("t1_depth", bit_depth_o, 1);
    check("t1_rate", sample_rate_o, 1);
    check("t1_done", done_cnt, 1);
    check("t1_error", error_o, 0);
    check("t1_idle_active", stream_active_o, 0);

    // ---- 2: backpressure after 3rd write ----
    wr_q.delete(); done_cnt = 0; full_wr_cnt = 0;
    fork
      begin
        send_header(8'h09, 32'h0000000C);
        send_payload(8'h10, 12, 1'b0);
      end
      begin
        int k;
        k = 0;
        while (wr_q.size() < 3 && k < 400) begin
          @(posedge clk_i);
          k++;
        end
        if (k >= 400) timeouts++;
        #1 wr_output_FIFO_full_i = 1'b1;
        repeat (5) begin
          @(negedge clk_i);
          check("t2_ready_full", rx_ready_o, 0);
          @(posedge clk_i); #1;
        end
        wr_output_FIFO_full_i = 1'b0;
      end
    join
    idle_cycles(4);
    check_writes("t2", 8'h10, 12);
    check("t2_full_writes", full_wr_cnt, 0);
    check("t2_done", done_cnt, 1);

    // ---- 3: bad length, abort, then a valid header ----
    wr_q.delete(); done_cnt = 0;
    send_header(8'h00, 32'h00000006);
    @(negedge clk_i);
    check("t3_error", error_o, 1);
    check("t3_ready", rx_ready_o, 0);
    check("t3_writes", wr_q.size(), 0);
    @(posedge clk_i); #1 abort_i = 1'b1;
    @(posedge clk_i); #1 abort_i = 1'b0;
    @(negedge clk_i);
    check("t3_err_clr", error_o, 0);
    check("t3_ready_idle", rx_ready_o, 1);
    check("t3_rate_kept", sample_rate_o, 1);
    @(posedge clk_i); #1;
    send_header(8'h12, 32'h00000008);
    @(negedge clk_i);
    check("t3_active", stream_active_o, 1);
    check("t3_rate", sample_rate_o, 2);
    check("t3_depth", bit_depth_o, 2);
    @(posedge clk_i); #1;
    send_payload(8'h20, 8, 1'b0);
    idle_cycles(4);
    check_writes("t3", 8'h20, 8);
    check("t3_done", done_cnt, 1);

    // ---- 4: CFG held off while transmitter streams ----
    wr_q.delete(); done_cnt = 0;
    output_streaming_i = 1'b1;
    send_byte(8'hA5);
    rx_data_i = 8'h1B; rx_valid_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("t4_ready_hold", rx_ready_o, 0);
    check("t4_rate_hold", sample_rate_o, 2);
    check("t4_depth_hold", bit_depth_o, 2);
    @(posedge clk_i); #1 output_streaming_i = 1'b0;
    @(negedge clk_i);
    check("t4_ready_rel", rx_ready_o, 1);
    @(posedge clk_i); #1 rx_valid_i = 1'b0;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h06);
    @(negedge clk_i);
    check("t4_rate", sample_rate_o, 3);
    check("t4_depth", bit_depth_o, 3);
    @(posedge clk_i); #1;
    send_payload(8'h30, 6, 1'b0);
    idle_cycles(4);
    check_writes("t4", 8'h30, 6);
    check("t4_done", done_cnt, 1);

    // ---- 5: abort after 4 of 8 bytes ----
    wr_q.delete(); done_cnt = 0;
    send_header(8'h00, 32'h00000008);
    for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i));
    idle_cycles(2);
    abort_i = 1'b1;
    @(posedge clk_i); #1 abort_i = 1'b0;
    idle_cycles(4);
    check_writes("t5", 8'h40, 4);
    check("t5_done", done_cnt, 0);
    check("t5_active", stream_active_o, 0);
    check("t5_ready_idle", rx_ready_o, 1);
    check("t5_error", error_o, 0);

`ifdef AUDIO_STREAM_CHECKSUM_EN
    // ---- 6: checksum trailer good and bad ----
    wr_q.delete(); done_cnt = 0;
    send_header(8'h00, 32'h00000004);
    send_payload(8'h01, 4, 1'b0);
    idle_cycles(4);
    check("t6_good_done", done_cnt, 1);
    check("t6_good_error", error_o, 0);
    wr_q.delete(); done_cnt = 0;
    send_header(8'h00, 32'h00000004);
    send_payload(8'h01, 4, 1'b1);
    idle_cycles(4);
    check("t6_bad_error", error_o, 1);
    check("t6_bad_done", done_cnt, 0);
    check_writes("t6_bad", 8'h01, 4);
    abort_i = 1'b1;
    @(posedge clk_i); #1 abort_i = 1'b0;
`endif

    // ---- reset mid-payload returns configuration to reset values ----
    send_header(8'h1B, 32'h00000006);
    send_byte(8'h50); send_byte(8'h51);
    reset_i = 1'b1;
    @(posedge clk_i); #1 reset_i = 1'b0;
    @(negedge clk_i);
    check("rst2_rate", sample_rate_o, 0);
    check("rst2_depth", bit_depth_o, 0);
    check("rst2_active", stream_active_o, 0);
    check("rst2_ready", rx_ready_o, 1);

    check("timeouts", timeouts, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
